// File: rtl/i2c_master_sequencer_if.sv
// rtl/i2c_master_sequencer_if.sv - requester and byte-engine signal bundle for the I2C master sequencer
interface i2c_master_sequencer_if #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 4
);
    // requester side
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_rw;
    logic [NREQ*7-1:0]     req_dev;
    logic [NREQ*8-1:0]     req_reg;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic [7:0]            wr_data;
    logic                  wr_ready;
    logic [7:0]            rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic                  done;
    logic                  err;
    // byte engine side
    logic                  eng_go;
    logic [1:0]            eng_cmd;
    logic [7:0]            eng_txd;
    logic                  eng_last;
    logic                  eng_done;
    logic                  eng_ack;
    logic [7:0]            eng_rxd;

    // the sequencer drives the transaction outputs and the engine commands
    modport master (
        input  req, req_rw, req_dev, req_reg, req_len, wr_data,
        input  eng_done, eng_ack, eng_rxd,
        output gnt, wr_ready, rd_data, rd_valid, busy, done, err,
        output eng_go, eng_cmd, eng_txd, eng_last
    );

    // requesters and byte engine as seen from outside the sequencer
    modport slave (
        output req, req_rw, req_dev, req_reg, req_len, wr_data,
        output eng_done, eng_ack, eng_rxd,
        input  gnt, wr_ready, rd_data, rd_valid, busy, done, err,
        input  eng_go, eng_cmd, eng_txd, eng_last
    );
endinterface

// File: rtl/i2c_master_sequencer.sv
// rtl/i2c_master_sequencer.sv - round-robin I2C register-access sequencer in front of a byte engine
module i2c_master_sequencer #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_a,
    i2c_master_sequencer_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_REG, S_RSTART,
        S_DEV_R, S_RDATA, S_WDATA, S_STOP, S_FIN
    } state_t;

    state_t           r_state;
    logic             r_wait;      // 0: issue phase of the step, 1: waiting for eng_done
    logic [IW-1:0]    r_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic             r_busy;
    logic             r_rw;
    logic [6:0]       r_dev;
    logic [7:0]       r_reg;
    logic [LEN_W-1:0] r_cnt;
    logic             r_go;
    logic [1:0]       r_cmd;
    logic [7:0]       r_txd;
    logic             r_last;
    logic             r_wr_ready;
    logic             r_rd_valid;
    logic [7:0]       r_rd_data;
    logic             r_done;
    logic             r_err;

    logic             w_found;
    logic [IW-1:0]    w_win;
    logic             w_wdata_go;
    logic             w_cnt_one;

    // round-robin search starting one past the last winner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && bus.req[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // write data is sampled in the very cycle wr_ready is shown, then held in r_txd
    assign w_wdata_go = r_go && (r_state == S_WDATA);
    assign w_cnt_one  = (r_cnt == LEN_W'(1));

    assign bus.gnt      = r_gnt;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.wr_ready = r_wr_ready;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.eng_go   = r_go;
    assign bus.eng_cmd  = r_cmd;
    assign bus.eng_txd  = w_wdata_go ? bus.wr_data : r_txd;
    assign bus.eng_last = r_last;

    // transaction FSM: arbitration, command issue/wait and step sequencing
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state    <= S_IDLE;
            r_wait     <= 1'b0;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_dev      <= '0;
            r_reg      <= '0;
            r_cnt      <= '0;
            r_go       <= 1'b0;
            r_cmd      <= C_START;
            r_txd      <= '0;
            r_last     <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_go       <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait <= 1'b0;
                    if (w_found) begin
                        r_gnt   <= NREQ'(1) << w_win;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_win;
                        r_rw    <= bus.req_rw[w_win];
                        r_dev   <= bus.req_dev[int'(w_win)*7 +: 7];
                        r_reg   <= bus.req_reg[int'(w_win)*8 +: 8];
                        r_cnt   <= bus.req_len[int'(w_win)*LEN_W +: LEN_W];
                        r_state <= S_START;
                    end
                end
                S_FIN: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    if (!r_wait) begin
                        r_go   <= 1'b1;
                        r_wait <= 1'b1;
                        r_last <= 1'b0;
                        r_txd  <= '0;
                        case (r_state)
                            S_START, S_RSTART: r_cmd <= C_START;
                            S_DEV_W: begin
                                r_cmd <= C_WRITE;
                                r_txd <= {r_dev, 1'b0};
                            end
                            S_REG: begin
                                r_cmd <= C_WRITE;
                                r_txd <= r_reg;
                            end
                            S_DEV_R: begin
                                r_cmd <= C_WRITE;
                                r_txd <= {r_dev, 1'b1};
                            end
                            S_WDATA: begin
                                r_cmd      <= C_WRITE;
                                r_wr_ready <= 1'b1;
                            end
                            S_RDATA: begin
                                r_cmd  <= C_READ;
                                r_last <= w_cnt_one;
                            end
                            default: r_cmd <= C_STOP;
                        endcase
                    end else begin
                        if (w_wdata_go) begin
                            r_txd <= bus.wr_data;
                        end
                        if (bus.eng_done) begin
                            r_wait <= 1'b0;
                            case (r_state)
                                S_START: r_state <= S_DEV_W;
                                S_DEV_W: begin
                                    if (!bus.eng_ack) begin
                                        r_err   <= 1'b1;
                                        r_state <= S_STOP;
                                    end else if (r_cnt == '0) begin
                                        r_state <= S_STOP;
                                    end else begin
                                        r_state <= S_REG;
                                    end
                                end
                                S_REG: begin
                                    if (!bus.eng_ack) begin
                                        r_err   <= 1'b1;
                                        r_state <= S_STOP;
                                    end else begin
                                        r_state <= r_rw ? S_RSTART : S_WDATA;
                                    end
                                end
                                S_RSTART: r_state <= S_DEV_R;
                                S_DEV_R: begin
                                    if (!bus.eng_ack) begin
                                        r_err   <= 1'b1;
                                        r_state <= S_STOP;
                                    end else begin
                                        r_state <= S_RDATA;
                                    end
                                end
                                S_RDATA: begin
                                    r_rd_valid <= 1'b1;
                                    r_rd_data  <= bus.eng_rxd;
                                    if (r_cnt != '0) begin
                                        r_cnt <= r_cnt - LEN_W'(1);
                                    end
                                    r_state <= w_cnt_one ? S_STOP : S_RDATA;
                                end
                                S_WDATA: begin
                                    if (!bus.eng_ack) begin
                                        r_err   <= 1'b1;
                                        r_state <= S_STOP;
                                    end else begin
                                        if (r_cnt != '0) begin
                                            r_cnt <= r_cnt - LEN_W'(1);
                                        end
                                        r_state <= w_cnt_one ? S_STOP : S_WDATA;
                                    end
                                end
                                default: begin
                                    r_done  <= 1'b1;
                                    r_state <= S_FIN;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/i2c_master_sequencer.md
Name: i2c_master_sequencer

Overview:
- Transaction-level controller in front of the I2C byte engine (START/WRITE/READ/STOP primitives with ack/int handshake).
- Arbitrates round-robin between NREQ requesters.
- Sequences a complete register-access transaction for the granted requester: START, device address, register address, optional repeated START, data bytes, STOP.
- Owns the byte engine exclusively; requesters never drive it directly.

Parameters:
NREQ, 2, number of requesters (>=2)
LEN_W, 4, width of per-request byte count

Ports:
clk  in  1  system clock
rst_a  in  1  asynchronous active-low reset
req  in  NREQ  per-requester transaction request, level
req_rw  in  NREQ  per-requester direction, 1=read 0=write
req_dev  in  NREQ*7  per-requester 7-bit device address, requester i at [7i+6:7i]
req_reg  in  NREQ*8  per-requester register address
req_len  in  NREQ*LEN_W  per-requester data byte count; 0 = address probe
gnt  out  NREQ  one-hot grant, held for whole transaction
wr_data  in  8  write byte from granted requester
wr_ready  out  1  pulse: wr_data consumed this cycle
rd_data  out  8  received byte
rd_valid  out  1  pulse: rd_data valid
busy  out  1  transaction in progress
done  out  1  pulse: transaction finished
err  out  1  valid with done: slave NACKed an address or write byte
eng_go  out  1  pulse: issue eng_cmd to byte engine
eng_cmd  out  2  00 START, 01 WRITE, 10 READ, 11 STOP
eng_txd  out  8  byte to transmit (WRITE)
eng_last  out  1  READ only: master NACKs this byte
eng_done  in  1  pulse: engine finished current command
eng_ack  in  1  slave ACK for WRITE, valid with eng_done
eng_rxd  in  8  received byte, valid with eng_done on READ

Behaviour:
Reset
- All outputs 0; state IDLE; round-robin pointer 0; latched fields cleared.
- Asserting rst_a mid-transaction aborts immediately with no STOP issued; the byte engine shares rst_a.

Arbitration (IDLE only)
- Any req high: grant the first requester at or after pointer+1 (mod NREQ).
- gnt and busy rise the next cycle; req_rw/dev/reg/len of the winner are latched.
- Pointer becomes the winner index.
- req changes after grant are ignored.
- gnt and busy fall in the cycle after done.

Command handshake
- Each step is ISSUE then WAIT.
- ISSUE: one-cycle eng_go with eng_cmd, eng_txd and eng_last stable.
- WAIT: hold outputs until eng_done.
- eng_done outside WAIT is ignored.
- First START eng_go occurs 1 cycle after gnt.

States: IDLE, START, DEV_W, REG, RSTART, DEV_R, RDATA, WDATA, STOP, FIN.

Write transaction
- START -> DEV_W (txd={dev,0}) -> REG (txd=reg) -> WDATA x len -> STOP.
- In each WDATA ISSUE cycle wr_ready=1 and eng_txd=wr_data, sampled that cycle.

Read transaction
- START -> DEV_W -> REG -> RSTART (cmd START) -> DEV_R (txd={dev,1}) -> RDATA x len -> STOP.
- eng_last=1 only on the final RDATA.
- Each RDATA eng_done produces rd_valid=1 and rd_data=eng_rxd the following cycle.

Probe
- len=0, either rw: START -> DEV_W -> STOP.

NACK
- eng_done with eng_ack=0 in DEV_W, REG, DEV_R or WDATA: set the sticky err flag and go straight to STOP.
- No further wr_ready or rd_valid pulses after the NACK.

Completion
- STOP eng_done -> FIN: done=1 for one cycle with err; err cleared on entering IDLE.

Counter
- LEN_W-bit down-counter loaded from len.
- Decremented on each data-byte eng_done.
- Leaves the data state when the count reaches 0; no wrap.

Simultaneous events
- req arriving during FIN waits until IDLE.
- A new grant can occur in the first IDLE cycle (back-to-back).

Test Plan:
- Write: req0, dev=0x50, reg=0x10, len=2, engine always ACKs -> commands START, WRITE 0xA0, WRITE 0x10, WRITE d0, WRITE d1, STOP; 2 wr_ready pulses; done=1, err=0.
- Read: req1, dev=0x50, rw=1, len=3, engine returns 0x11/0x22/0x33 -> START, WRITE 0xA0, WRITE reg, START, WRITE 0xA1, READ x3 with eng_last on the 3rd only, STOP; rd_valid pulses 0x11, 0x22, 0x33.
- NACK: eng_ack=0 on the device-address byte -> next command STOP, no wr_ready, done with err=1; err=0 on the next transaction.
- Arbitration: req0 and req1 held high -> grants alternate 1,0,1,0; gnt stays one-hot and stable throughout each transaction.
- Probe/reset: len=0 -> START, WRITE addr, STOP only; rst_a low mid-RDATA -> all outputs 0 immediately, next req granted normally from pointer 0.
